// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_pkg
// Purpose  : Shared types and address-split width helpers for the data cache.
// Revision : 1.0 - initial release
// ============================================================================
package dcache_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Word-offset field width within a line
  function automatic int offset_w(input int words);
    return $clog2(words);
  endfunction

  // Line-index field width
  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  // Tag width: whatever is left above index, offset and the byte bits
  function automatic int tag_w(input int lines, input int words);
    return 32 - $clog2(lines) - $clog2(words) - 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_line_array.sv
`default_nettype none
// ============================================================================
// Module   : dcache_line_array
// Purpose  : Tag, valid and data storage for a direct-mapped cache.
//            Asynchronous read, synchronous single-word and tag+valid writes,
//            valid bits cleared asynchronously by reset.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int LINES    = 16,
  parameter int WORDS    = 4,
  parameter int INDEX_W  = index_w(LINES),
  parameter int OFFSET_W = offset_w(WORDS),
  parameter int TAG_W    = tag_w(LINES, WORDS)
) (
  input  logic                clk,
  input  logic                rst,
  // lookup port
  input  logic [INDEX_W-1:0]  rd_index_i,
  input  logic [OFFSET_W-1:0] rd_offset_i,
  output logic                rd_valid_o,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic [31:0]         rd_word_o,
  // single-word data write
  input  logic                wr_en_i,
  input  logic [INDEX_W-1:0]  wr_index_i,
  input  logic [OFFSET_W-1:0] wr_offset_i,
  input  logic [31:0]         wr_data_i,
  // tag + valid write
  input  logic                tv_we_i,
  input  logic [INDEX_W-1:0]  tv_index_i,
  input  logic [TAG_W-1:0]    tv_tag_i,
  input  logic                tv_valid_i
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][WORDS];

  // Valid bits: the only state in the array that reset touches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (tv_we_i) begin
      valid_q[tv_index_i] <= tv_valid_i;
    end
  end

  // Tag store, written together with the valid bit
  always_ff @(posedge clk) begin
    if (tv_we_i) begin
      tag_q[tv_index_i] <= tv_tag_i;
    end
  end

  // Data store, one word per clock
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      data_q[wr_index_i][wr_offset_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_word_o  = data_q[rd_index_i][rd_offset_i];

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Purpose  : Direct-mapped, write-through, no-write-allocate data cache
//            controller. Read hits are combinational; misses refill a whole
//            line beat by beat and stores are written through to memory,
//            with the pipeline stalled meanwhile.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  localparam int OFFSET_W = offset_w(WORDS);
  localparam int INDEX_W  = index_w(LINES);
  localparam int TAG_W    = tag_w(LINES, WORDS);
  localparam int IDX_LO   = OFFSET_W + 2;
  localparam int TAG_LO   = OFFSET_W + INDEX_W + 2;

  state_e              state_q, state_d;
  logic [OFFSET_W-1:0] beat_q, beat_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;

  // CPU address split
  logic [OFFSET_W-1:0] w_cpu_off;
  logic [INDEX_W-1:0]  w_cpu_idx;
  logic [TAG_W-1:0]    w_cpu_tag;
  logic                w_unused;

  assign w_cpu_off = cpu_addr_i[IDX_LO-1:2];
  assign w_cpu_idx = cpu_addr_i[TAG_LO-1:IDX_LO];
  assign w_cpu_tag = cpu_addr_i[31:TAG_LO];
  // Byte-select bits play no part in a word cache
  assign w_unused  = &{1'b0, cpu_addr_i[1:0]};

  // Array interface
  logic                w_rd_valid;
  logic [TAG_W-1:0]    w_rd_tag;
  logic [31:0]         w_rd_word;
  logic                w_arr_we;
  logic [INDEX_W-1:0]  w_arr_idx;
  logic [OFFSET_W-1:0] w_arr_off;
  logic [31:0]         w_arr_data;
  logic                w_tv_we;
  logic                w_hit;
  logic [31:0]         w_beat_addr;

  assign w_hit       = cpu_req_i & w_rd_valid & (w_rd_tag == w_cpu_tag);
  assign w_beat_addr = addr_q | {{(30-OFFSET_W){1'b0}}, beat_q, 2'b00};

  dcache_line_array #(
    .LINES    (LINES),
    .WORDS    (WORDS),
    .INDEX_W  (INDEX_W),
    .OFFSET_W (OFFSET_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .rd_index_i  (w_cpu_idx),
    .rd_offset_i (w_cpu_off),
    .rd_valid_o  (w_rd_valid),
    .rd_tag_o    (w_rd_tag),
    .rd_word_o   (w_rd_word),
    .wr_en_i     (w_arr_we),
    .wr_index_i  (w_arr_idx),
    .wr_offset_i (w_arr_off),
    .wr_data_i   (w_arr_data),
    .tv_we_i     (w_tv_we),
    .tv_index_i  (addr_q[TAG_LO-1:IDX_LO]),
    .tv_tag_i    (addr_q[31:TAG_LO]),
    .tv_valid_i  (1'b1)
  );

  // State, beat counter and address/data latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state, stall, memory-port and array-write decode
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_stall_o = 1'b0;
    cpu_rdata_o = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    w_arr_we    = 1'b0;
    w_arr_idx   = w_cpu_idx;
    w_arr_off   = w_cpu_off;
    w_arr_data  = cpu_wdata_i;
    w_tv_we     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req_i) begin
          if (cpu_we_i) begin
            // Store: update the line only on a hit, always write through
            cpu_stall_o = 1'b1;
            w_arr_we    = w_hit;
            addr_d      = {cpu_addr_i[31:2], 2'b00};
            wdata_d     = cpu_wdata_i;
            state_d     = ST_WRITE;
          end else if (w_hit) begin
            cpu_rdata_o = w_rd_word;
          end else begin
            cpu_stall_o = 1'b1;
            addr_d      = {cpu_addr_i[31:IDX_LO], {IDX_LO{1'b0}}};
            beat_d      = '0;
            state_d     = ST_REFILL;
          end
        end
      end

      ST_REFILL: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = w_beat_addr;
        if (mem_ack_i) begin
          w_arr_we   = 1'b1;
          w_arr_idx  = addr_q[TAG_LO-1:IDX_LO];
          w_arr_off  = beat_q;
          w_arr_data = mem_rdata_i;
          beat_d     = beat_q + OFFSET_W'(1);
          if (beat_q == OFFSET_W'(WORDS-1)) begin
            // Line becomes visible only once every word is in place
            w_tv_we = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      ST_WRITE: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        if (mem_ack_i) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // One unstalled cycle lets the pipeline retire the store
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache between the CPU's MEM stage and a slow, handshaked data memory. It serves MEM-stage loads and stores and asserts a stall that freezes every pipeline latch and the PC while a miss refill or a write-through is in progress. Read hits complete combinationally with no stall; all other accesses go through a small FSM.

## Interface
- `LINES`, 16: number of cache lines; power of two, at least 2.
- `WORDS`, 4: 32-bit words per line; power of two, at least 2.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `cpu_req_i` in 1: MEM-stage access valid (MemRead or MemWrite).
- `cpu_we_i` in 1: 1 = store, 0 = load.
- `cpu_addr_i` in 32: byte address; bits [1:0] are ignored.
- `cpu_wdata_i` in 32: store data.
- `cpu_rdata_o` out 32: load data; valid when `cpu_req_i & !cpu_we_i & !cpu_stall_o`.
- `cpu_stall_o` out 1: freeze PC and all pipeline latches.
- `mem_req_o` out 1: memory request.
- `mem_we_o` out 1: memory write.
- `mem_addr_o` out 32: word-aligned memory address.
- `mem_wdata_o` out 32: memory write data.
- `mem_rdata_i` in 32: memory read data; valid in the `mem_ack_i` cycle.
- `mem_ack_i` in 1: beat complete; sampled on the rising edge.

## Operation
- **Address split**
  - offset = addr[1+log2(WORDS):2]
  - index = next log2(LINES) bits
  - tag = the remaining upper bits
- **Hit:** `cpu_req_i & valid[index] & (tag_array[index]==tag)`.
- **FSM states:** IDLE, REFILL, WRITE, DONE.
- **IDLE**
  - No request: stall 0, no memory activity.
  - Read hit: `cpu_rdata_o` = line word, stall 0, stay in IDLE.
  - Read miss: stall 1 combinationally. Latch the line base address, set beat counter to 0, go to REFILL.
  - Write, hit or miss: stall 1. On a hit, update the cached word at this clock edge. Latch addr/wdata, go to WRITE.
- **REFILL**
  - Drive `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o` = base + 4·beat.
  - On each ack, write `mem_rdata_i` into word[beat] and increment beat.
  - On the ack of beat WORDS-1: set valid, write the tag, go to IDLE. The retried load then hits.
- **WRITE**
  - Drive `mem_req_o`=1, `mem_we_o`=1, and the latched addr/wdata.
  - On ack, go to DONE. A write miss does not allocate.
- **DONE:** stall 0 for exactly one cycle so the pipeline advances past the store. No memory activity. Go to IDLE.
- **Stall:** `cpu_stall_o` = 1 in REFILL and WRITE, and in IDLE on a read miss or any write.
- **Memory outputs:** `mem_addr_o`/`mem_we_o`/`mem_wdata_o` are held stable while `mem_req_o` is high and un-acked. They are 0 when `mem_req_o`=0.
- **`cpu_rdata_o`:** 0 when there is no read hit.
- **Reset:** `rst` low at any time forces IDLE, clears all valid bits and the beat counter, and drops `mem_req_o` immediately.
  - A refill aborted by reset leaves its line invalid.
  - Tag and data arrays are not reset.
- **CPU contract:** `cpu_req_i`/`cpu_we_i`/`cpu_addr_i`/`cpu_wdata_i` stay stable while `cpu_stall_o`=1. The bench asserts this.

## Timing
- Read hit: 0 stall cycles; data combinational from the array.
- Read miss with zero-wait memory (ack in the request cycle): 1 + WORDS stall cycles, i.e. 5 at defaults. The load completes in the following cycle.
- Write with zero-wait memory: 2 stall cycles, then the DONE cycle with stall 0.
- Each memory wait cycle adds one stall cycle.
- Only one memory transaction is outstanding at a time.
- A back-to-back request in the cycle after DONE is evaluated normally in IDLE.

## Structure
- Shared package `dcache_pkg`:
  - state enum (IDLE, REFILL, WRITE, DONE)
  - localparam functions for OFFSET_W, INDEX_W, TAG_W
- Sub-module `dcache_line_array` holds the tag, valid and data arrays:
  - async read
  - synchronous single-word write
  - tag+valid write
  - async valid clear
- `dcache_ctrl` holds the FSM, beat counter, address latch and output muxing.

## Test plan
- Reset, then load 0x0000_0040 with memory returning 0x11,0x22,0x33,0x44 at zero wait:
  - stall for 5 cycles
  - memory addresses 0x40,0x44,0x48,0x4C
  - the completing load returns 0x11
  - a load of 0x48 next hits with no stall and returns 0x33
- Store 0xDEAD_BEEF to 0x44 (hit):
  - one memory write to 0x44
  - stall 2 cycles, then DONE
  - a later load of 0x44 hits and returns 0xDEAD_BEEF
- Store to an uncached 0x1000:
  - memory write issued
  - a following load of 0x1000 misses and refills
- Conflict: load 0x40, then load 0x140 (same index, different tag):
  - second load refills
  - reloading 0x40 misses again
- Memory with 3 wait cycles per beat on a read miss:
  - stall lasts 1 + 4·4 = 17 cycles
  - `mem_addr_o` stable during the waits
- Assert `rst` low at beat 2 of a refill:
  - `mem_req_o` drops immediately
  - after release, a load of the same address misses and refills fully
